bullet_controller: RTL and testbench

- Per-player bullet engine that sits directly upstream of the colour mapper and generates its bullet-related inputs: is_bullet, bullet X/Y, is_shooting and hit.
- Launches a 16x16 bullet from the shooter tank's leading edge and moves it once per video frame.
- Detects collision against the opposing tank's 32x32 box and keeps a saturating 2-bit hit score.

---
 rtl/bullet_controller.sv | 180 ++++++++++++++++++
 tb/tb_bullet_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - per-player bullet engine: launch, per-frame motion, target collision and hit score
module bullet_controller #(
    parameter logic [9:0] BULLET_SPEED = 10'd4,
    parameter logic [9:0] BULLET_SIZE  = 10'd16,
    parameter logic [9:0] TANK_SIZE    = 10'd32,
    parameter logic [9:0] SCREEN_W     = 10'd640,
    parameter logic [9:0] SCREEN_H     = 10'd480,
    parameter logic [5:0] HIT_FRAMES   = 6'd30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [2:0] tank_dir,
    input  logic [9:0] tankX,
    input  logic [9:0] tankY,
    input  logic [9:0] targetX,
    input  logic [9:0] targetY,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_bullet,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       is_shooting,
    output logic [1:0] hit
);

    typedef enum logic [1:0] {IDLE, FLYING, HIT} state_t;

    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_RIGHT = 3'b010;
    localparam logic [2:0] DIR_LEFT  = 3'b011;
    localparam logic [2:0] DIR_DOWN  = 3'b100;

    localparam logic signed [10:0] MAX_X  = signed'({1'b0, SCREEN_W - BULLET_SIZE});
    localparam logic signed [10:0] MAX_Y  = signed'({1'b0, SCREEN_H - BULLET_SIZE});
    localparam logic signed [10:0] SIZE_S = signed'({1'b0, BULLET_SIZE});
    localparam logic signed [10:0] TANK_S = signed'({1'b0, TANK_SIZE});
    localparam logic signed [10:0] HALF_S = signed'({1'b0, (TANK_SIZE - BULLET_SIZE) >> 1});
    localparam logic signed [10:0] SPD_S  = signed'({1'b0, BULLET_SPEED});
    localparam logic signed [11:0] TANK_W = signed'({2'b00, TANK_SIZE});
    localparam logic signed [11:0] SIZE_W = signed'({2'b00, BULLET_SIZE});

    state_t            state, state_next;
    logic              frame_clk_delayed;
    logic              tick;
    logic              armed;
    logic              launch;
    logic [2:0]        dir, dir_next;
    logic [5:0]        hit_cnt, hit_cnt_next;
    logic [1:0]        hit_next;
    logic [9:0]        bx_next, by_next;
    logic              dir_valid;
    logic signed [10:0] tank_x_s, tank_y_s, cur_x_s, cur_y_s;
    logic signed [10:0] spawn_x, spawn_y, move_x, move_y;
    logic signed [11:0] move_x_w, move_y_w, tgt_x_w, tgt_y_w;
    logic              overlap;

    function automatic logic on_screen(input logic signed [10:0] x, input logic signed [10:0] y);
        return (x >= 11'sd0) && (x <= MAX_X) && (y >= 11'sd0) && (y <= MAX_Y);
    endfunction

    assign tick      = frame_clk & ~frame_clk_delayed;
    assign tank_x_s  = signed'({1'b0, tankX});
    assign tank_y_s  = signed'({1'b0, tankY});
    assign cur_x_s   = signed'({1'b0, bulletX});
    assign cur_y_s   = signed'({1'b0, bulletY});
    assign dir_valid = (tank_dir == DIR_UP) || (tank_dir == DIR_RIGHT) ||
                       (tank_dir == DIR_LEFT) || (tank_dir == DIR_DOWN);

    always_comb begin
        spawn_x = tank_x_s;
        spawn_y = tank_y_s;
        case (tank_dir)
            DIR_UP:    begin spawn_x = tank_x_s + HALF_S; spawn_y = tank_y_s - SIZE_S; end
            DIR_RIGHT: begin spawn_x = tank_x_s + TANK_S; spawn_y = tank_y_s + HALF_S; end
            DIR_LEFT:  begin spawn_x = tank_x_s - SIZE_S; spawn_y = tank_y_s + HALF_S; end
            DIR_DOWN:  begin spawn_x = tank_x_s + HALF_S; spawn_y = tank_y_s + TANK_S; end
            default:   ;
        endcase
    end

    always_comb begin
        move_x = cur_x_s;
        move_y = cur_y_s;
        case (dir)
            DIR_UP:    move_y = cur_y_s - SPD_S;
            DIR_RIGHT: move_x = cur_x_s + SPD_S;
            DIR_LEFT:  move_x = cur_x_s - SPD_S;
            DIR_DOWN:  move_y = cur_y_s + SPD_S;
            default:   ;
        endcase
    end

    // Box overlap is evaluated one bit wider so target+32 cannot wrap.
    assign move_x_w = {move_x[10], move_x};
    assign move_y_w = {move_y[10], move_y};
    assign tgt_x_w  = signed'({2'b00, targetX});
    assign tgt_y_w  = signed'({2'b00, targetY});
    assign overlap  = (move_x_w < tgt_x_w + TANK_W) && (move_x_w + SIZE_W > tgt_x_w) &&
                      (move_y_w < tgt_y_w + TANK_W) && (move_y_w + SIZE_W > tgt_y_w);

    always_comb begin
        state_next   = state;
        bx_next      = bulletX;
        by_next      = bulletY;
        dir_next     = dir;
        hit_next     = hit;
        hit_cnt_next = hit_cnt;
        launch       = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (fire && armed && dir_valid && on_screen(spawn_x, spawn_y)) begin
                        launch     = 1'b1;
                        bx_next    = spawn_x[9:0];
                        by_next    = spawn_y[9:0];
                        dir_next   = tank_dir;
                        state_next = FLYING;
                    end
                end
                FLYING: begin
                    if (overlap) begin
                        bx_next      = move_x[9:0];
                        by_next      = move_y[9:0];
                        hit_cnt_next = 6'd0;
                        state_next   = HIT;
                        if (hit != 2'd3) hit_next = hit + 2'd1;
                    end else if (!on_screen(move_x, move_y)) begin
                        state_next = IDLE;
                    end else begin
                        bx_next = move_x[9:0];
                        by_next = move_y[9:0];
                    end
                end
                HIT: begin
                    if (hit_cnt == HIT_FRAMES - 6'd1) begin
                        hit_cnt_next = 6'd0;
                        state_next   = IDLE;
                    end else begin
                        hit_cnt_next = hit_cnt + 6'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state             <= IDLE;
            bulletX           <= 10'd0;
            bulletY           <= 10'd0;
            dir               <= 3'd0;
            hit               <= 2'd0;
            hit_cnt           <= 6'd0;
            armed             <= 1'b1;
            frame_clk_delayed <= 1'b0;
        end else begin
            state             <= state_next;
            bulletX           <= bx_next;
            bulletY           <= by_next;
            dir               <= dir_next;
            hit               <= hit_next;
            hit_cnt           <= hit_cnt_next;
            frame_clk_delayed <= frame_clk;
            // A held fire button must be released before the next launch.
            if (launch)     armed <= 1'b0;
            else if (!fire) armed <= 1'b1;
        end
    end

    assign is_shooting = (state == FLYING);
    assign is_bullet   = (state == FLYING) &&
                         ({1'b0, DrawX} >= {1'b0, bulletX}) &&
                         ({1'b0, DrawX} <  {1'b0, bulletX} + {1'b0, BULLET_SIZE}) &&
                         ({1'b0, DrawY} >= {1'b0, bulletY}) &&
                         ({1'b0, DrawY} <  {1'b0, bulletY} + {1'b0, BULLET_SIZE});

endmodule

// File: tb/tb_bullet_controller.sv
// tb/tb_bullet_controller.sv - self-checking bench for bullet_controller
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [2:0] tank_dir = 3'b001;
    logic [9:0] tankX = '0, tankY = '0, targetX = '0, targetY = '0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       is_bullet, is_shooting;
    logic [9:0] bulletX, bulletY;
    logic [1:0] hit;

    int checks = 0;
    int errors = 0;
    int launches = 0;
    logic shoot_q = 1'b0;

    bullet_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire), .tank_dir(tank_dir),
        .tankX(tankX), .tankY(tankY), .targetX(targetX), .targetY(targetY),
        .DrawX(DrawX), .DrawY(DrawY), .is_bullet(is_bullet), .bulletX(bulletX),
        .bulletY(bulletY), .is_shooting(is_shooting), .hit(hit)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (is_shooting && !shoot_q) launches++;
        shoot_q = is_shooting;
    end

    typedef struct {
        logic [2:0] dir;
        logic [9:0] tx;
        logic [9:0] ty;
        int         shoot;
        int         ex;
        int         ey;
    } vec_t;

    typedef struct {
        int shoot;
        int x;
        int y;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        fire = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic draw(input int x, input int y, input int exp, input string name);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        chk(name, int'(is_bullet), exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        exp_t e;
        vecs[0]  = '{3'b001, 10'd100, 10'd200, 1, 108, 184};
        vecs[1]  = '{3'b010, 10'd100, 10'd100, 1, 132, 108};
        vecs[2]  = '{3'b011, 10'd100, 10'd100, 1,  84, 108};
        vecs[3]  = '{3'b100, 10'd100, 10'd100, 1, 108, 132};
        vecs[4]  = '{3'b011, 10'd8,   10'd100, 0,   0,   0};
        vecs[5]  = '{3'b001, 10'd100, 10'd10,  0,   0,   0};
        vecs[6]  = '{3'b010, 10'd592, 10'd100, 1, 624, 108};
        vecs[7]  = '{3'b010, 10'd593, 10'd100, 0,   0,   0};
        vecs[8]  = '{3'b100, 10'd100, 10'd432, 1, 108, 464};
        vecs[9]  = '{3'b100, 10'd100, 10'd433, 0,   0,   0};
        vecs[10] = '{3'b000, 10'd100, 10'd100, 0,   0,   0};
        vecs[11] = '{3'b111, 10'd100, 10'd100, 0,   0,   0};
        vecs[12] = '{3'b011, 10'd16,  10'd0,   1,   0,   8};

        Reset = 1'b1;
        #12;
        chk("reset is_shooting", int'(is_shooting), 0);
        chk("reset bulletX", int'(bulletX), 0);
        chk("reset hit", int'(hit), 0);
        @(negedge Clk) Reset = 1'b0;

        // launch table: spawn offsets and screen-edge validity
        targetX = 10'd0;
        targetY = 10'd0;
        for (int i = 0; i < 13; i++) begin
            do_reset();
            tank_dir = vecs[i].dir;
            tankX = vecs[i].tx;
            tankY = vecs[i].ty;
            fire = 1'b1;
            sb.push_back('{vecs[i].shoot, vecs[i].ex, vecs[i].ey});
            tick();
            fire = 1'b0;
            e = sb.pop_front();
            chk($sformatf("vec%0d is_shooting", i), int'(is_shooting), e.shoot);
            chk($sformatf("vec%0d bulletX", i), int'(bulletX), e.x);
            chk($sformatf("vec%0d bulletY", i), int'(bulletY), e.y);
        end

        // up launch, motion and sprite window
        do_reset();
        targetX = 10'd500; targetY = 10'd400;
        tank_dir = 3'b001; tankX = 10'd100; tankY = 10'd200;
        fire = 1'b1; tick(); fire = 1'b0;
        chk("up spawn Y", int'(bulletY), 184);
        tick();
        chk("up move X", int'(bulletX), 108);
        chk("up move Y", int'(bulletY), 180);
        draw(108, 180, 1, "is_bullet top-left");
        draw(123, 195, 1, "is_bullet bottom-right");
        draw(124, 180, 0, "is_bullet right edge");
        draw(108, 196, 0, "is_bullet bottom edge");
        tank_dir = 3'b000; tick();
        chk("latched dir Y", int'(bulletY), 176);
        chk("latched dir shooting", int'(is_shooting), 1);

        // suppressed launch keeps armed
        do_reset();
        tank_dir = 3'b011; tankX = 10'd8; tankY = 10'd100;
        fire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("suppressed tick%0d", i), int'(is_shooting), 0);
        end
        tankX = 10'd40; tick();
        chk("unsuppressed shooting", int'(is_shooting), 1);
        chk("unsuppressed X", int'(bulletX), 24);
        chk("unsuppressed Y", int'(bulletY), 108);
        fire = 1'b0;

        // collision and HIT dwell
        do_reset();
        targetX = 10'd200; targetY = 10'd100;
        tank_dir = 3'b010; tankX = 10'd100; tankY = 10'd100;
        fire = 1'b1; tick(); fire = 1'b0;
        ticks(13);
        chk("pre-hit X", int'(bulletX), 184);
        chk("pre-hit shooting", int'(is_shooting), 1);
        chk("pre-hit score", int'(hit), 0);
        tick();
        chk("hit X", int'(bulletX), 188);
        chk("hit score", int'(hit), 1);
        chk("hit shooting", int'(is_shooting), 0);
        draw(188, 108, 0, "hit is_bullet");
        fire = 1'b1;
        ticks(29);
        chk("HIT ignores fire", int'(is_shooting), 0);
        tick();
        chk("HIT exit tick no launch", int'(is_shooting), 0);
        tick();
        chk("relaunch after HIT", int'(is_shooting), 1);
        chk("relaunch X", int'(bulletX), 132);
        fire = 1'b0;

        // screen exit on the right
        do_reset();
        targetX = 10'd0; targetY = 10'd400;
        tank_dir = 3'b010; tankX = 10'd588; tankY = 10'd100;
        fire = 1'b1; tick(); fire = 1'b0;
        chk("exit spawn X", int'(bulletX), 620);
        tick();
        chk("exit 624 X", int'(bulletX), 624);
        chk("exit 624 shooting", int'(is_shooting), 1);
        tick();
        chk("exit shooting", int'(is_shooting), 0);
        chk("exit X held", int'(bulletX), 624);
        chk("exit score", int'(hit), 0);

        // held fire gives one bullet; release re-arms
        do_reset();
        tank_dir = 3'b010; tankX = 10'd560; tankY = 10'd100;
        base = launches;
        fire = 1'b1;
        ticks(15);
        chk("autofire launches", launches - base, 1);
        chk("autofire idle", int'(is_shooting), 0);
        @(negedge Clk) fire = 1'b0;
        @(negedge Clk) fire = 1'b1;
        tick();
        chk("rearm launches", launches - base, 2);

        // hit saturation
        do_reset();
        targetX = 10'd140; targetY = 10'd100;
        tank_dir = 3'b010; tankX = 10'd100; tankY = 10'd100;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk) fire = 1'b0;
            @(negedge Clk) fire = 1'b1;
            tick();
            tick();
            chk($sformatf("score hit%0d", k), int'(hit), (k < 2) ? k + 1 : 3);
            ticks(30);
        end

        // async reset mid-flight
        @(negedge Clk) fire = 1'b0;
        @(negedge Clk) fire = 1'b1;
        tick();
        fire = 1'b0;
        chk("pre-reset shooting", int'(is_shooting), 1);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("async is_shooting", int'(is_shooting), 0);
        chk("async bulletX", int'(bulletX), 0);
        chk("async bulletY", int'(bulletY), 0);
        chk("async hit", int'(hit), 0);
        @(negedge Clk) Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
